// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared sequencer state type and frame-count width for the MFCC front end
package mfcc_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_WIN    = 3'd1,
    S_STREAM      = 3'd2,
    S_DRAIN       = 3'd3,
    S_MOVE        = 3'd4,
    S_WAIT_REFILL = 3'd5
  } state_t;

endpackage

// File: rtl/sample_skid_buffer.sv
// rtl/sample_skid_buffer.sv - 2-entry output FIFO between window reads and the downstream stream
module sample_skid_buffer #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_valid = (r_count != 2'd0);
  assign w_pop   = o_valid && i_ready;
  assign w_push  = i_valid && ((r_count != 2'd2) || w_pop);
  // Head is forced to zero when empty so a cleared buffer shows all-zero data.
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - reads one frame from the window buffer, streams it out, then shifts the window (FRAME_SEQUENCER_STATS_EN adds counters)
module frame_sequencer
  import mfcc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAME_SIZE = 400,
  parameter int ADDR_W     = 10,
  parameter int MAX_FRAMES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   window_valid_i,
  output logic                   start_move_o,
  output logic                   rd_en_o,
  output logic [ADDR_W-1:0]      rd_addr_o,
  input  logic [WIDTH-1:0]       rd_data_i,
  output logic [WIDTH-1:0]       sample_o,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic                   frame_first_o,
  output logic                   frame_last_o,
`ifdef FRAME_SEQUENCER_STATS_EN
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic [31:0]            stall_cycles_o,
`endif
  output logic                   busy_o
);

  localparam logic [ADDR_W-1:0]      LAST_ADDR   = ADDR_W'(FRAME_SIZE - 1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_LIMIT = FRAME_CNT_W'(MAX_FRAMES);

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_addr;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_inflight;
  logic                   r_infl_first;
  logic                   r_infl_last;
  logic                   r_seen_low;
  logic                   w_limit;
  logic                   w_go;
  logic                   w_pop;
  logic [1:0]             w_occ;
  logic [2:0]             w_pending;
  logic [WIDTH+1:0]       w_head;

  assign w_limit = (MAX_FRAMES != 0) && (r_frame_cnt == FRAME_LIMIT);
  assign w_go    = enable_i && !w_limit;
  assign w_pop   = sample_valid_o && sample_ready_i;

  // A slot freed by this cycle's pop counts as free, which is what sustains 1 sample/cycle.
  assign w_pending    = {1'b0, w_occ} - {2'b0, w_pop} + {2'b0, r_inflight};
  assign rd_en_o      = (r_state == S_STREAM) && (w_pending < 3'd2);
  assign rd_addr_o    = r_addr;
  assign start_move_o = (r_state == S_MOVE);
  assign busy_o       = (r_state != S_IDLE);
  assign {frame_first_o, frame_last_o, sample_o} = w_head;

  sample_skid_buffer #(
    .W(WIDTH + 2)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_inflight),
    .i_data  ({r_infl_first, r_infl_last, rd_data_i}),
    .o_valid (sample_valid_o),
    .o_data  (w_head),
    .i_ready (sample_ready_i),
    .o_count (w_occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_frame_cnt  <= '0;
      r_inflight   <= 1'b0;
      r_infl_first <= 1'b0;
      r_infl_last  <= 1'b0;
      r_seen_low   <= 1'b0;
    end else begin
      r_inflight <= rd_en_o;
      if (rd_en_o) begin
        r_infl_first <= (r_addr == '0);
        r_infl_last  <= (r_addr == LAST_ADDR);
      end
      case (r_state)
        S_IDLE: begin
          if (w_go) r_state <= S_WAIT_WIN;
        end
        S_WAIT_WIN: begin
          if (window_valid_i) begin
            r_state <= S_STREAM;
            r_addr  <= '0;
          end
        end
        S_STREAM: begin
          if (rd_en_o) begin
            if (r_addr == LAST_ADDR) r_state <= S_DRAIN;
            else                     r_addr  <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_pop && frame_last_o) r_state <= S_MOVE;
        end
        S_MOVE: begin
          r_seen_low <= 1'b0;
          if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 1'b1;
          r_state <= S_WAIT_REFILL;
        end
        S_WAIT_REFILL: begin
          // The shifted window must be seen invalid before a new valid counts as a refill.
          if (!window_valid_i)  r_seen_low <= 1'b1;
          else if (r_seen_low)  r_state    <= w_go ? S_WAIT_WIN : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FRAME_SEQUENCER_STATS_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (sample_valid_o && !sample_ready_i && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign frame_count_o  = r_frame_cnt;
  assign stall_cycles_o = r_stall;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer, optional FRAME_SEQUENCER_STATS_EN ports
module tb_frame_sequencer;

  localparam int FS   = 400;
  localparam int AW   = 10;
  localparam int STEP = 160;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_i = 1'b0;
  logic          window_valid_i = 1'b0;
  logic          sample_ready_i = 1'b0;
  logic          start_move_o, rd_en_o, sample_valid_o, frame_first_o, frame_last_o, busy_o;
  logic [AW-1:0] rd_addr_o;
  logic [15:0]   rd_data_i = '0;
  logic [15:0]   sample_o;
`ifdef FRAME_SEQUENCER_STATS_EN
  logic [15:0]   frame_count_o;
  logic [31:0]   stall_cycles_o;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0, move_total = 0, xfer_total = 0, rd_total = 0, k = 0, rd_exp = 0, model_stall = 0;
  int first_cyc = 0, last_cyc = 0, first_rd_addr = -1;
  int rdy_mode = 0;
  logic want_first_rd = 1'b0;
  logic auto_refill = 1'b0;
  logic [15:0] first_data = '0, last_data = '0, base = '0;

  always #5 clk = ~clk;

  frame_sequencer #(
    .WIDTH(16), .FRAME_SIZE(FS), .ADDR_W(AW), .MAX_FRAMES(3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .window_valid_i (window_valid_i),
    .start_move_o   (start_move_o),
    .rd_en_o        (rd_en_o),
    .rd_addr_o      (rd_addr_o),
    .rd_data_i      (rd_data_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .frame_first_o  (frame_first_o),
    .frame_last_o   (frame_last_o),
`ifdef FRAME_SEQUENCER_STATS_EN
    .frame_count_o  (frame_count_o),
    .stall_cycles_o (stall_cycles_o),
`endif
    .busy_o         (busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Window buffer stand-in: every shift advances the visible samples by STEP.
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= base + 16'(rd_addr_o);
    if (start_move_o) base <= base + 16'(STEP);
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: sample_ready_i = 1'b1;
      1: sample_ready_i = ~sample_ready_i;
      default: ;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (auto_refill && start_move_o && !rst) begin
      window_valid_i = 1'b0;
      repeat (4) @(negedge clk);
      window_valid_i = 1'b1;
    end
  end

  // Model: sample k of frame f carries f*STEP + k; reads walk 0..FS-1; a shift only follows the last sample.
  initial forever begin
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    if (rst) begin
      chk("reset_outputs", {start_move_o, rd_en_o, rd_addr_o, sample_o, sample_valid_o,
                            frame_first_o, frame_last_o, busy_o}, 32'd0);
`ifdef FRAME_SEQUENCER_STATS_EN
      chk("reset_frame_count", 32'(frame_count_o), 32'd0);
      chk("reset_stall", stall_cycles_o, 32'd0);
`endif
      k = 0;
      rd_exp = 0;
      model_stall = 0;
      want_first_rd = 1'b1;
    end else begin
      if (rd_en_o) begin
        chk("rd_addr", 32'(rd_addr_o), rd_exp);
        if (want_first_rd) begin
          first_rd_addr = int'(rd_addr_o);
          want_first_rd = 1'b0;
        end
        rd_exp = (rd_exp + 1) % FS;
        rd_total++;
      end
      if (sample_valid_o && !sample_ready_i) model_stall++;
      if (sample_valid_o && sample_ready_i) begin
        e = 16'(move_total * STEP + k);
        chk("sample_data", 32'(sample_o), 32'(e));
        chk("frame_first", 32'(frame_first_o), 32'(k == 0));
        chk("frame_last", 32'(frame_last_o), 32'(k == FS - 1));
        if (k == 0) begin
          first_data = sample_o;
          first_cyc = cyc;
        end
        if (k == FS - 1) begin
          last_data = sample_o;
          last_cyc = cyc;
        end
        k = (k + 1) % FS;
        xfer_total++;
      end
      if (start_move_o) begin
        chk("move_after_last", k, 0);
        move_total++;
      end
      if (rd_en_o || sample_valid_o || start_move_o) chk("busy_active", 32'(busy_o), 32'd1);
    end
  end

  task automatic wait_moves(input int target, input int budget);
    int n = 0;
    while (move_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_moves", move_total, target);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfer_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_xfers", 32'(xfer_total >= target), 32'd1);
  endtask

  initial begin
    int lat_rd, lat_v, m0, x0;
    enable_i = 1'b1;
    window_valid_i = 1'b1;
    sample_ready_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Frame 1: ready high, window valid at release.
    lat_rd = -1;
    lat_v = -1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rd_en_o && lat_rd < 0) lat_rd = n;
      if (sample_valid_o && lat_v < 0) lat_v = n;
    end
    chk("latency_first_read", lat_rd, 2);
    chk("latency_first_valid", lat_v, 4);
    wait_moves(1, 2000);
    chk("t1_xfers", xfer_total, FS);
    chk("t1_first_data", 32'(first_data), 32'd0);
    chk("t1_last_data", 32'(last_data), 32'd399);
    chk("t1_throughput", last_cyc - first_cyc, FS - 1);

    // Valid held high after the shift: nothing may restart.
    repeat (600) @(negedge clk);
    chk("t2_no_restart_moves", move_total, 1);
    chk("t2_no_restart_reads", rd_total, FS);
    chk("t2_busy_waiting", 32'(busy_o), 32'd1);

    // Frame 2: low-then-high refill, ready toggling every cycle.
    rdy_mode = 1;
    window_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    window_valid_i = 1'b1;
    wait_moves(2, 4000);
    chk("t2_xfers", xfer_total, 2 * FS);
    chk("t2_first_data", 32'(first_data), 32'd160);
    chk("t2_last_data", 32'(last_data), 32'd559);

    // Frame 3: reset near sample 200, then the frame restarts from address 0.
    rdy_mode = 0;
    window_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    window_valid_i = 1'b1;
    x0 = xfer_total;
    wait_xfers(x0 + 200, 1500);
    rst = 1'b1;
    #1;
    chk("t3_reset_immediate", {start_move_o, rd_en_o, rd_addr_o, sample_o, sample_valid_o,
                               frame_first_o, frame_last_o, busy_o}, 32'd0);
    m0 = move_total;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    x0 = xfer_total;
    wait_moves(m0 + 1, 2000);
    chk("t3_one_move", move_total, m0 + 1);
    chk("t3_restart_addr", first_rd_addr, 0);
    chk("t3_xfers", xfer_total - x0, FS);
    chk("t3_first_data", 32'(first_data), 32'd320);

    // Frame limit of 3 with automatic refills and one 10-cycle downstream stall.
    @(negedge clk);
    rst = 1'b1;
    auto_refill = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m0 = move_total;
    x0 = xfer_total;
    wait_xfers(x0 + 50, 1000);
    rdy_mode = 3;
    @(posedge clk);
    #1 sample_ready_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 sample_ready_i = 1'b1;
    rdy_mode = 0;
    wait_moves(m0 + 2, 3000);
    @(posedge clk);
    #1;
`ifdef FRAME_SEQUENCER_STATS_EN
    chk("t4_frame_count_2", 32'(frame_count_o), 32'd2);
`endif
    begin
      int n = 0;
      while (busy_o && n < 5000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_idle", 32'(busy_o), 32'd0);
    chk("t4_moves", move_total - m0, 3);
    repeat (300) @(negedge clk);
    chk("t4_stays_idle_moves", move_total - m0, 3);
    chk("t4_stays_idle_busy", 32'(busy_o), 32'd0);
    chk("t4_model_stall", model_stall, 10);
`ifdef FRAME_SEQUENCER_STATS_EN
    chk("t4_frame_count_3", 32'(frame_count_o), 32'd3);
    chk("t4_stall_cycles", stall_cycles_o, 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter FRAME_SIZE, default 400, samples per frame.
REQ-003 SHALL have parameter ADDR_W, default 10, window read address width; FRAME_SIZE <= 2**ADDR_W.
REQ-004 SHALL have parameter MAX_FRAMES, default 0, frames before auto-stop; 0 means unlimited.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port enable_i, input, 1: level; 1 allows new frames to start.
REQ-008 SHALL have port window_valid_i, input, 1: window buffer holds a complete frame (valid_to_read).
REQ-009 SHALL have port start_move_o, output, 1: one-cycle pulse commanding the window buffer to shift by its move size.
REQ-010 SHALL have port rd_en_o, input-side strobe, output, 1: window read request.
REQ-011 SHALL have port rd_addr_o, output, ADDR_W: frame-relative sample index for the current read.
REQ-012 SHALL have port rd_data_i, input, WIDTH: window data, valid exactly 1 cycle after rd_en_o.
REQ-013 SHALL have ports sample_o (output, WIDTH), sample_valid_o (output, 1), sample_ready_i (input, 1): downstream valid/ready stream.
REQ-014 SHALL have ports frame_first_o and frame_last_o, output, 1: qualify sample_o as sample 0 / sample FRAME_SIZE-1.
REQ-015 SHALL have port busy_o, output, 1: high in any state except IDLE.

Function
REQ-016 SHALL implement states IDLE, WAIT_WIN, STREAM, DRAIN, MOVE, WAIT_REFILL.
REQ-017 IDLE -> WAIT_WIN when enable_i=1 and frame limit not reached.
REQ-018 WAIT_WIN -> STREAM when window_valid_i=1; rd_addr counter cleared to 0.
REQ-019 STREAM SHALL assert rd_en_o only when output-buffer occupancy plus in-flight reads < 2; rd_addr_o increments by 1 per rd_en_o.
REQ-020 STREAM -> DRAIN after the read with rd_addr_o = FRAME_SIZE-1 is issued.
REQ-021 Output SHALL be a 2-entry FIFO; sample transfers when sample_valid_o & sample_ready_i; no sample lost or duplicated under any ready pattern.
REQ-022 DRAIN -> MOVE when the last sample (frame_last_o=1) transfers.
REQ-023 MOVE SHALL pulse start_move_o for exactly 1 cycle, increment frame count, then -> WAIT_REFILL.
REQ-024 WAIT_REFILL SHALL wait for window_valid_i to be observed low then high; then -> WAIT_WIN if enable_i=1 and limit not reached, else IDLE.
REQ-025 If window_valid_i is low in the cycle after MOVE and never was high, the low-then-high rule SHALL still apply (a held-high valid never restarts a frame).
REQ-026 enable_i deasserting mid-frame SHALL NOT abort; the frame completes through MOVE.
REQ-027 Frame count SHALL be 16 bits, saturating at 16'hFFFF; limit check SHALL be count == MAX_FRAMES when MAX_FRAMES != 0.
REQ-028 Streaming throughput SHALL be 1 sample/cycle with sample_ready_i held high; first sample_valid_o 2 cycles after entering STREAM.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, empty output FIFO, counters 0, discard in-flight read.
REQ-030 During reset all outputs SHALL be 0, including sample_o.
REQ-031 Reset mid-frame SHALL leave no start_move_o pulse; after release the block starts at sample 0.

Configuration
REQ-032 With macro FRAME_SEQUENCER_STATS_EN defined, ports frame_count_o (16 bits, frame count) and stall_cycles_o (32 bits, saturating count of cycles with sample_valid_o=1 and sample_ready_i=0) SHALL exist, reset to 0.
REQ-033 Without FRAME_SEQUENCER_STATS_EN, those ports and their counters SHALL be absent; all other behaviour identical.

Structure
REQ-034 State enum type and frame-count width constant SHALL reside in the shared package mfcc_pkg.
REQ-035 The 2-entry output FIFO SHALL be a sub-module named sample_skid_buffer; everything else inline.

Verification
REQ-036 Ready held 1, window_valid_i=1 at reset release -> 400 samples, addresses 0..399 in order, frame_first_o on sample 0, frame_last_o on sample 399, one start_move_o pulse.
REQ-037 sample_ready_i toggling 1/0 every cycle -> exactly 400 transfers, no duplicates, data matches rd_addr order.
REQ-038 window_valid_i held high after MOVE -> no second frame until valid drops low then rises.
REQ-039 MAX_FRAMES=3, enable_i=1 -> exactly 3 start_move_o pulses, then IDLE and busy_o=0.
REQ-040 rst asserted at sample 200 -> all outputs 0 immediately; after release next frame begins at rd_addr_o=0.
REQ-041 With FRAME_SEQUENCER_STATS_EN, ready low 10 cycles while valid -> stall_cycles_o=10; after 2 frames frame_count_o=2.
